// File: rtl/bridge_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bridge_arbiter
// Description : Round-robin arbiter that shares one DRAM bridge command port
//               between N_REQ requesters. One transaction is outstanding at a
//               time. The winner's command is latched and held on the C_* port
//               until the bridge answers with c_out_valid. The result is then
//               routed back to the winner as a one-cycle resp_valid pulse.
//
// Ports       :
//   clk, rst            clock, synchronous active-high reset
//   req_valid[N]        per-requester request, held until acked
//   req_r_wb[N]         per-requester direction (1 = read, 0 = write)
//   req_addr            packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_data_w          packed write data, requester i at [i*DATA_W +: DATA_W]
//   req_ack[N]          one-hot 1-cycle pulse: request accepted
//   resp_valid[N]       one-hot 1-cycle pulse: transaction complete
//   resp_data           read data during the resp_valid cycle, 0 otherwise
//   c_in_valid          1-cycle command strobe to the bridge
//   c_r_wb/c_addr/
//   c_data_w            command to the bridge, held until the next grant
//   c_out_valid         completion strobe from the bridge
//   c_data_r            read data from the bridge
//   busy                high from the ack cycle to the resp cycle inclusive
//
// Optional    : define BRIDGE_ARB_PERF_CNT_EN to add the saturating counters
//               perf_txn_cnt (16 bit, completed transactions) and
//               perf_busy_cycles (32 bit, cycles with busy high).
//
// Revision    : 1.0 - initial release
// ============================================================================
module bridge_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_r_wb,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_data_w,
  output logic [N_REQ-1:0]          req_ack,
  output logic [N_REQ-1:0]          resp_valid,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      c_in_valid,
  output logic                      c_r_wb,
  output logic [ADDR_W-1:0]         c_addr,
  output logic [DATA_W-1:0]         c_data_w,
  input  logic                      c_out_valid,
  input  logic [DATA_W-1:0]         c_data_r,
  output logic                      busy
`ifdef BRIDGE_ARB_PERF_CNT_EN
  ,
  output logic [15:0]               perf_txn_cnt,
  output logic [31:0]               perf_busy_cycles
`endif
);

  // Pointer width; one extra bit lets the wrap-around sum be formed without
  // overflow before it is folded back into 0..N_REQ-1.
  localparam int c_ptr_w = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int c_sum_w = c_ptr_w + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Registered state and outputs
  // --------------------------------------------------------------------------
  state_t               r_state;
  logic [c_ptr_w-1:0]   r_rr_ptr;
  logic [c_ptr_w-1:0]   r_owner;      // requester that owns the transaction
  logic [N_REQ-1:0]     r_ack;
  logic [N_REQ-1:0]     r_resp_valid;
  logic [DATA_W-1:0]    r_resp_data;
  logic                 r_c_in_valid;
  logic                 r_c_r_wb;
  logic [ADDR_W-1:0]    r_c_addr;
  logic [DATA_W-1:0]    r_c_data_w;
  logic                 r_busy;

  // --------------------------------------------------------------------------
  // Next-state values
  // --------------------------------------------------------------------------
  state_t               w_state_nxt;
  logic [c_ptr_w-1:0]   w_rr_ptr_nxt;
  logic [c_ptr_w-1:0]   w_owner_nxt;
  logic [N_REQ-1:0]     w_ack_nxt;
  logic [N_REQ-1:0]     w_resp_valid_nxt;
  logic [DATA_W-1:0]    w_resp_data_nxt;
  logic                 w_c_in_valid_nxt;
  logic                 w_c_r_wb_nxt;
  logic [ADDR_W-1:0]    w_c_addr_nxt;
  logic [DATA_W-1:0]    w_c_data_w_nxt;
  logic                 w_busy_nxt;

  // Arbitration results
  logic                 w_any_req;
  logic [c_ptr_w-1:0]   w_winner;
  logic [c_sum_w-1:0]   w_sum;
  logic [ADDR_W-1:0]    w_sel_addr;
  logic [DATA_W-1:0]    w_sel_data;
  logic                 w_sel_r_wb;

  // --------------------------------------------------------------------------
  // Round-robin search: first set request at or after r_rr_ptr, wrapping.
  // The loop runs from the farthest candidate down to the pointer itself so
  // the last hit written is the nearest one in search order.
  // --------------------------------------------------------------------------
  always_comb begin
    w_any_req = |req_valid;
    w_winner  = '0;
    w_sum     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr_ptr} + c_sum_w'(k);
      if (w_sum >= c_sum_w'(N_REQ)) begin
        w_sum = w_sum - c_sum_w'(N_REQ);
      end
      if (req_valid[w_sum[c_ptr_w-1:0]]) begin
        w_winner = w_sum[c_ptr_w-1:0];
      end
    end
  end

  // Winner payload, sampled only in the arbitration cycle
  always_comb begin
    w_sel_addr = req_addr[int'(w_winner) * ADDR_W +: ADDR_W];
    w_sel_data = req_data_w[int'(w_winner) * DATA_W +: DATA_W];
    w_sel_r_wb = req_r_wb[w_winner];
  end

  // --------------------------------------------------------------------------
  // FSM next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_rr_ptr_nxt     = r_rr_ptr;
    w_owner_nxt      = r_owner;
    w_ack_nxt        = '0;
    w_resp_valid_nxt = '0;
    w_resp_data_nxt  = '0;
    w_c_in_valid_nxt = 1'b0;
    w_c_r_wb_nxt     = r_c_r_wb;
    w_c_addr_nxt     = r_c_addr;
    w_c_data_w_nxt   = r_c_data_w;
    w_busy_nxt       = r_busy;

    case (r_state)
      S_IDLE: begin
        w_busy_nxt = 1'b0;
        if (w_any_req) begin
          w_state_nxt    = S_ISSUE;
          w_owner_nxt    = w_winner;
          w_ack_nxt      = {{(N_REQ-1){1'b0}}, 1'b1} << w_winner;
          w_busy_nxt     = 1'b1;
          w_c_r_wb_nxt   = w_sel_r_wb;
          w_c_addr_nxt   = w_sel_addr;
          w_c_data_w_nxt = w_sel_data;
          if (w_winner == c_ptr_w'(N_REQ - 1)) begin
            w_rr_ptr_nxt = '0;
          end else begin
            w_rr_ptr_nxt = w_winner + 1'b1;
          end
        end
      end

      // The ack is visible during ISSUE; the bridge strobe follows next cycle.
      S_ISSUE: begin
        w_c_in_valid_nxt = 1'b1;
        w_state_nxt      = S_WAIT;
      end

      // Command registers are untouched here, so the bridge sees a stable
      // command for as long as it takes to answer.
      S_WAIT: begin
        if (c_out_valid) begin
          w_state_nxt      = S_RESP;
          w_resp_valid_nxt = {{(N_REQ-1){1'b0}}, 1'b1} << r_owner;
          w_resp_data_nxt  = r_c_r_wb ? c_data_r : '0;
        end
      end

      S_RESP: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_owner      <= '0;
      r_ack        <= '0;
      r_resp_valid <= '0;
      r_resp_data  <= '0;
      r_c_in_valid <= 1'b0;
      r_c_r_wb     <= 1'b0;
      r_c_addr     <= '0;
      r_c_data_w   <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_rr_ptr     <= w_rr_ptr_nxt;
      r_owner      <= w_owner_nxt;
      r_ack        <= w_ack_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_data  <= w_resp_data_nxt;
      r_c_in_valid <= w_c_in_valid_nxt;
      r_c_r_wb     <= w_c_r_wb_nxt;
      r_c_addr     <= w_c_addr_nxt;
      r_c_data_w   <= w_c_data_w_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  assign req_ack    = r_ack;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign c_in_valid = r_c_in_valid;
  assign c_r_wb     = r_c_r_wb;
  assign c_addr     = r_c_addr;
  assign c_data_w   = r_c_data_w;
  assign busy       = r_busy;

`ifdef BRIDGE_ARB_PERF_CNT_EN
  // --------------------------------------------------------------------------
  // Saturating performance counters
  // --------------------------------------------------------------------------
  logic [15:0] r_perf_txn;
  logic [31:0] r_perf_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_txn  <= '0;
      r_perf_busy <= '0;
    end else begin
      if ((r_state == S_RESP) && (r_perf_txn != '1)) begin
        r_perf_txn <= r_perf_txn + 16'd1;
      end
      if (r_busy && (r_perf_busy != '1)) begin
        r_perf_busy <= r_perf_busy + 32'd1;
      end
    end
  end

  assign perf_txn_cnt     = r_perf_txn;
  assign perf_busy_cycles = r_perf_busy;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bridge_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bridge_arbiter
// Description : Self-checking bench for bridge_arbiter. A transaction-level
//               timeline model predicts every output each cycle; directed
//               scenarios add literal expectations for timing, ordering,
//               reset abort and (when BRIDGE_ARB_PERF_CNT_EN is defined) the
//               performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bridge_arbiter;
  localparam int N_REQ  = 4;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N_REQ-1:0]        req_valid, req_r_wb, req_ack, resp_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_data_w;
  logic [DATA_W-1:0]       resp_data, c_data_w;
  logic [DATA_W-1:0]       c_data_r = '0;
  logic                    c_in_valid, c_r_wb, busy;
  logic                    c_out_valid = 1'b0;
  logic [ADDR_W-1:0]       c_addr;
`ifdef BRIDGE_ARB_PERF_CNT_EN
  logic [15:0]             perf_txn_cnt;
  logic [31:0]             perf_busy_cycles;
`endif

  bridge_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_r_wb(req_r_wb),
    .req_addr(req_addr), .req_data_w(req_data_w),
    .req_ack(req_ack), .resp_valid(resp_valid), .resp_data(resp_data),
    .c_in_valid(c_in_valid), .c_r_wb(c_r_wb), .c_addr(c_addr),
    .c_data_w(c_data_w), .c_out_valid(c_out_valid), .c_data_r(c_data_r),
    .busy(busy)
`ifdef BRIDGE_ARB_PERF_CNT_EN
    , .perf_txn_cnt(perf_txn_cnt), .perf_busy_cycles(perf_busy_cycles)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // --------------------------------------------------------------------------
  // Requesters: requester i keeps req_valid high while it has un-acked work
  // --------------------------------------------------------------------------
  int                want[N_REQ];
  int                acked[N_REQ];
  logic              rwb_a[N_REQ];
  logic [ADDR_W-1:0] addr_a[N_REQ];
  logic [DATA_W-1:0] data_a[N_REQ];

  always_comb begin
    req_valid  = '0;
    req_r_wb   = '0;
    req_addr   = '0;
    req_data_w = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_valid[i] = (acked[i] < want[i]);
      req_r_wb[i]  = rwb_a[i];
      req_addr[i*ADDR_W +: ADDR_W]   = addr_a[i];
      req_data_w[i*DATA_W +: DATA_W] = data_a[i];
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (req_ack[i] === 1'b1) acked[i] = acked[i] + 1;
    end
  end

  // --------------------------------------------------------------------------
  // Bridge model: answers br_lat cycles after the c_in_valid cycle
  // --------------------------------------------------------------------------
  int                br_lat  = 1;
  int                br_cnt  = 0;
  logic [DATA_W-1:0] br_data = '0;
  logic              spur    = 1'b0;

  always @(negedge clk) begin
    c_data_r = br_data;
    if (rst) begin
      br_cnt      = 0;
      c_out_valid = 1'b0;
    end else begin
      c_out_valid = spur;
      if (br_cnt > 0) begin
        br_cnt = br_cnt - 1;
        if (br_cnt == 0) c_out_valid = 1'b1;
      end
      if (c_in_valid === 1'b1) br_cnt = br_lat;
    end
  end

  // --------------------------------------------------------------------------
  // Reference model: one transaction as a timeline of cycle numbers.
  // ack at m_ack_t, bridge strobe at m_ack_t+1, response one cycle after the
  // first c_out_valid seen from m_ack_t+1 on, busy over the whole span.
  // --------------------------------------------------------------------------
  bit                m_on = 1'b0;
  bit                m_active = 1'b0;
  int                m_ptr = 0, m_win = 0, m_ack_t = 0, m_resp_t = -1;
  logic              m_rwb = 1'b0, m_crwb = 1'b0;
  logic [ADDR_W-1:0] m_caddr = '0;
  logic [DATA_W-1:0] m_cdata = '0, m_rdata = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_on = 1'b1; m_active = 1'b0; m_ptr = 0; m_resp_t = -1;
      m_crwb = 1'b0; m_caddr = '0; m_cdata = '0;
    end else if (m_on) begin
      if (m_active && m_resp_t == cyc) begin
        m_active = 1'b0;
      end else if (m_active && m_resp_t < 0 && cyc >= m_ack_t + 1 && c_out_valid === 1'b1) begin
        m_resp_t = cyc + 1;
        m_rdata  = m_rwb ? c_data_r : '0;
      end else if (!m_active && req_valid != '0) begin
        bit found;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
          if (!found && req_valid[(m_ptr + k) % N_REQ]) begin
            found = 1'b1;
            m_win = (m_ptr + k) % N_REQ;
          end
        end
        m_active = 1'b1;
        m_ack_t  = cyc + 1;
        m_resp_t = -1;
        m_rwb    = rwb_a[m_win];
        m_crwb   = rwb_a[m_win];
        m_caddr  = addr_a[m_win];
        m_cdata  = data_a[m_win];
        m_ptr    = (m_win + 1) % N_REQ;
      end
    end
    cyc = cyc + 1;
  end

  // --------------------------------------------------------------------------
  // Per-cycle compare plus event recording for the directed checks
  // --------------------------------------------------------------------------
  int                ack_q[$];
  int                resp_cnt = 0, resp1_cnt = 0;
  int                last_ack_t = -1, last_cin_t = -1, last_resp_t = -1;
  logic [N_REQ-1:0]  last_ack = '0, last_resp_v = '0;
  logic [ADDR_W-1:0] last_cin_addr = '0;
  logic [DATA_W-1:0] last_cin_data = '0, last_resp_d = '0;
  logic              last_cin_rwb = 1'b0;

  always @(negedge clk) begin
    logic [N_REQ-1:0] e_ack, e_resp;
    if (m_on) begin
      e_ack  = (m_active && cyc == m_ack_t)  ? (N_REQ'(1) << m_win) : '0;
      e_resp = (m_active && cyc == m_resp_t) ? (N_REQ'(1) << m_win) : '0;
      check("req_ack",    req_ack,    e_ack);
      check("resp_valid", resp_valid, e_resp);
      check("resp_data",  resp_data,  (e_resp != '0) ? m_rdata : '0);
      check("c_in_valid", c_in_valid, (m_active && cyc == m_ack_t + 1) ? 1 : 0);
      check("c_r_wb",     c_r_wb,     m_crwb);
      check("c_addr",     c_addr,     m_caddr);
      check("c_data_w",   c_data_w,   m_cdata);
      check("busy",       busy,       m_active ? 1 : 0);
    end
    if (req_ack != '0 && !$isunknown(req_ack)) begin
      for (int i = 0; i < N_REQ; i++) if (req_ack[i]) ack_q.push_back(i);
      last_ack_t = cyc; last_ack = req_ack;
    end
    if (c_in_valid === 1'b1) begin
      last_cin_t = cyc; last_cin_addr = c_addr;
      last_cin_data = c_data_w; last_cin_rwb = c_r_wb;
    end
    if (resp_valid != '0 && !$isunknown(resp_valid)) begin
      resp_cnt++;
      if (resp_valid[1]) resp1_cnt++;
      last_resp_t = cyc; last_resp_v = resp_valid; last_resp_d = resp_data;
    end
  end

  // --------------------------------------------------------------------------
  // Directed scenarios
  // --------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(input int i, input logic rwb, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
    rwb_a[i] = rwb; addr_a[i] = a; data_a[i] = d;
    want[i] = want[i] + 1;
  endtask

  task automatic wait_resp(input int target, input int budget, input string nm);
    int k;
    k = 0;
    while (resp_cnt < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({"done_", nm}, (resp_cnt >= target) ? 1 : 0, 1);
  endtask

  initial begin
    int t0, r0;
    for (int i = 0; i < N_REQ; i++) begin
      want[i] = 0; acked[i] = 0; rwb_a[i] = 1'b0; addr_a[i] = '0; data_a[i] = '0;
    end
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    check("rst_ack",  req_ack, 0);
    check("rst_resp", resp_valid, 0);
    check("rst_cin",  c_in_valid, 0);
    check("rst_addr", c_addr, 0);
    check("rst_busy", busy, 0);

    // Single read from requester 0, bridge latency 5
    br_lat = 5; br_data = 64'hDEAD_BEEF_0000_0001;
    issue(0, 1'b1, 8'h12, 64'h0);
    t0 = cyc;
    wait_resp(1, 40, "read");
    check("read_ack_t",  last_ack_t, t0 + 1);
    check("read_ack",    last_ack, 4'b0001);
    check("read_cin_t",  last_cin_t, t0 + 2);
    check("read_addr",   last_cin_addr, 8'h12);
    check("read_resp_t", last_resp_t, t0 + 8);
    check("read_resp_v", last_resp_v, 4'b0001);
    check("read_data",   last_resp_d, 64'hDEAD_BEEF_0000_0001);
    tick(2);

    // Write from requester 2; bridge data must not leak into resp_data
    br_lat = 2; br_data = 64'hFFFF_FFFF_FFFF_FFFF;
    issue(2, 1'b0, 8'hFF, 64'h0123_4567_89AB_CDEF);
    wait_resp(2, 40, "write");
    check("write_rwb",    last_cin_rwb, 0);
    check("write_cdata",  last_cin_data, 64'h0123_4567_89AB_CDEF);
    check("write_resp_v", last_resp_v, 4'b0100);
    check("write_data",   last_resp_d, 0);
    tick(2);

    // Wrap/skip: pointer now 3, requesters 1 and 3 together -> 3 then 1
    ack_q.delete();
    br_lat = 1;
    issue(1, 1'b1, 8'h01, 64'h0);
    issue(3, 1'b1, 8'h03, 64'h0);
    wait_resp(4, 60, "wrap");
    check("wrap_n", ack_q.size(), 2);
    if (ack_q.size() == 2) begin
      check("wrap_first",  ack_q[0], 3);
      check("wrap_second", ack_q[1], 1);
    end
    tick(2);

    // Spurious c_out_valid while idle
    r0 = resp_cnt;
    spur = 1'b1; tick(1); spur = 1'b0;
    tick(4);
    check("spur_resp", resp_cnt, r0);
    check("spur_busy", busy, 0);
    ack_q.delete();
    issue(0, 1'b1, 8'h34, 64'h0);
    br_data = 64'h5555_AAAA_5555_AAAA;
    wait_resp(r0 + 1, 40, "after_spur");
    check("spur_next_ack", (ack_q.size() > 0) ? ack_q[0] : -1, 0);
    check("spur_next_data", last_resp_d, 64'h5555_AAAA_5555_AAAA);

    // Round robin: all four held valid for 8 transactions
    rst = 1'b1; tick(2); rst = 1'b0;
    ack_q.delete();
    r0 = resp_cnt;
    for (int i = 0; i < N_REQ; i++) begin
      issue(i, i[0], 8'(8'h40 + i), 64'(i * 3));
      issue(i, i[0], 8'(8'h40 + i), 64'(i * 3));
    end
    wait_resp(r0 + 8, 200, "rr");
    check("rr_n", ack_q.size(), 8);
    for (int k = 0; k < 8; k++) begin
      if (k < ack_q.size()) check("rr_order", ack_q[k], k % 4);
    end
    tick(2);

    // Reset while waiting on the bridge
    br_lat = 10;
    issue(1, 1'b1, 8'h56, 64'h0);
    tick(4);
    check("abort_busy", busy, 1);
    r0 = resp1_cnt;
    rst = 1'b1;
    tick(1);
    check("abort_ack",  req_ack, 0);
    check("abort_resp", resp_valid, 0);
    check("abort_rdat", resp_data, 0);
    check("abort_cin",  c_in_valid, 0);
    check("abort_rwb",  c_r_wb, 0);
    check("abort_addr", c_addr, 0);
    check("abort_busy0", busy, 0);
    tick(1);
    rst = 1'b0;
    br_lat = 1;
    ack_q.delete();
    t0 = resp_cnt;
    issue(0, 1'b1, 8'h61, 64'h0);
    issue(2, 1'b1, 8'h62, 64'h0);
    wait_resp(t0 + 2, 60, "after_abort");
    check("abort_next_first", (ack_q.size() > 0) ? ack_q[0] : -1, 0);
    tick(20);
    check("abort_no_resp", resp1_cnt, r0);

`ifdef BRIDGE_ARB_PERF_CNT_EN
    // Three transactions of six busy cycles each
    rst = 1'b1; tick(2); rst = 1'b0;
    check("perf_rst_txn", perf_txn_cnt, 0);
    br_lat = 3;
    r0 = resp_cnt;
    issue(3, 1'b1, 8'h70, 64'h0);
    issue(3, 1'b1, 8'h70, 64'h0);
    issue(3, 1'b1, 8'h70, 64'h0);
    wait_resp(r0 + 3, 80, "perf");
    tick(3);
    check("perf_txn",  perf_txn_cnt, 3);
    check("perf_busy", perf_busy_cycles, 18);
`endif

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/bridge_arbiter.md
Name: bridge_arbiter

Overview:
- Round-robin arbiter sharing one DRAM bridge between N_REQ requesters.
- Each requester issues single read or write transactions. The arbiter grants one, latches its command and presents it to the bridge's C_* port. It holds that command stable until the bridge returns C_out_valid, then routes the result back to the winning requester.
- Sits between the per-channel front-end controllers and the bridge. Only one transaction is outstanding at a time.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- ADDR_W, 8, transaction address width (bridge C_addr width)
- DATA_W, 64, data width (bridge C_data_w / C_data_r width)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  N_REQ  per-requester request; held high until acked
- req_r_wb  in  N_REQ  per-requester 1=read, 0=write
- req_addr  in  N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_data_w  in  N_REQ*DATA_W  packed write data
- req_ack  out  N_REQ  one-hot, 1-cycle pulse: request i accepted
- resp_valid  out  N_REQ  one-hot, 1-cycle pulse: transaction of requester i complete
- resp_data  out  DATA_W  read data (valid with resp_valid; 0 otherwise)
- c_in_valid  out  1  to bridge C_in_valid
- c_r_wb  out  1  to bridge C_r_wb
- c_addr  out  ADDR_W  to bridge C_addr
- c_data_w  out  DATA_W  to bridge C_data_w
- c_out_valid  in  1  from bridge C_out_valid
- c_data_r  in  DATA_W  from bridge C_data_r
- busy  out  1  high from ack cycle until resp cycle, inclusive

Behaviour:
- Reset (rst=1 at a clock edge) forces the following to 0: state=IDLE, rr_ptr=0, req_ack, resp_valid, resp_data, c_in_valid, c_r_wb, c_addr, c_data_w, busy. An in-flight transaction is abandoned; no resp is issued.
- Reset precondition: the bridge must also be in reset in the same cycle. This keeps the two sides consistent.
- All outputs are registered.

FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req_valid is set, pick a winner: the first set bit at or after rr_ptr, searching upward with wrap from N_REQ-1 to 0.
  - Next cycle: req_ack[winner]=1, busy=1, and the winner's r_wb/addr/data_w are latched into c_r_wb/c_addr/c_data_w. Go to ISSUE.
  - rr_ptr <= (winner+1) mod N_REQ.
  - No req_valid set: stay in IDLE; rr_ptr unchanged.
- ISSUE: c_in_valid=1 for exactly this one cycle. Go to WAIT.
- WAIT:
  - c_r_wb/c_addr/c_data_w are held constant. The bridge re-samples them every cycle.
  - On c_out_valid=1: capture c_data_r (reads) or 0 (writes) into resp_data. Go to RESP.
  - There is no timeout.
- RESP:
  - resp_valid[winner]=1 for one cycle. resp_data is valid this cycle only.
  - Go to IDLE. busy drops the cycle after RESP.
  - A new grant is earliest the cycle after RESP: arbitration happens in IDLE and the ack appears one cycle later.
- c_addr, c_r_wb and c_data_w remain at the last transaction's values while in IDLE. They are cleared only by reset.
- c_out_valid outside WAIT is ignored. A pulse there is a protocol error; it causes no state change.
- Requester i dropping req_valid before its ack is legal; it is then not granted. Payload is sampled only on the arbitration cycle.
- Minimum turnaround: 4 cycles plus bridge latency per transaction.
- Fairness: a requester held valid is granted within N_REQ transactions.

Optional Feature:
- Macro: BRIDGE_ARB_PERF_CNT_EN.
- Defined:
  - Adds output ports perf_txn_cnt (16 bits) and perf_busy_cycles (32 bits).
  - perf_txn_cnt increments in every RESP cycle.
  - perf_busy_cycles increments every cycle busy=1.
  - Both saturate at all-ones (no wrap) and reset to 0 on rst.
- Not defined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Single read: rst for 2 cycles, req_valid=4'b0001, r_wb=1, addr=8'h12, bridge model returns 64'hDEAD_BEEF_0000_0001 after 5 cycles -> req_ack=0001 at T+1; c_in_valid high at T+2 with c_addr=8'h12; c_addr stays stable until c_out_valid; resp_valid=0001 with that data the cycle after c_out_valid.
- Write: requester 2 writes addr=8'hFF, data=64'h0123_4567_89AB_CDEF -> c_r_wb=0, c_data_w equals that data throughout WAIT; resp_valid=0100 with resp_data=0.
- Round-robin: all four req_valid held high for 8 transactions -> ack order 0,1,2,3,0,1,2,3; each ack is 1 cycle and one-hot.
- Wrap/skip: rr_ptr=3 after granting 2, only requesters 1 and 3 valid -> 3 granted, then 1.
- Reset in WAIT: assert rst while waiting -> next cycle all outputs 0 and state IDLE; no resp_valid is ever issued for the aborted request; a following request from requester 0 is granted first.
- Spurious c_out_valid in IDLE -> no resp_valid, no state change. With BRIDGE_ARB_PERF_CNT_EN, after 3 transactions of 6 busy cycles each -> perf_txn_cnt=3 and perf_busy_cycles=18.
